// File: rtl/riscv_hwloop_regs_if.sv
// Hardware-loop register file bus.
// Carries the write port (start/end/count data, per-field write enables,
// target set index), the decrement request lines from the loop controller
// with their qualifiers (valid, flush), and the per-set read-back outputs.
//   master : loop controller / decoder side (drives writes and decrements)
//   slave  : register file side (drives stored values and flags)
interface riscv_hwloop_regs_if #(
   parameter int unsigned N_REGS     = 2,
   parameter int unsigned N_REG_BITS = $clog2(N_REGS)
);
   logic [31:0]                  hwlp_start_data_i;
   logic [31:0]                  hwlp_end_data_i;
   logic [31:0]                  hwlp_cnt_data_i;
   logic [2:0]                   hwlp_we_i;
   logic [N_REG_BITS-1:0]        hwlp_regid_i;
   logic                         valid_i;
   logic                         flush_i;
   logic [N_REGS-1:0]            hwlp_dec_cnt_i;
   logic [N_REGS-1:0][31:0]      hwlp_start_addr_o;
   logic [N_REGS-1:0][31:0]      hwlp_end_addr_o;
   logic [N_REGS-1:0][31:0]      hwlp_counter_o;
   logic [N_REGS-1:0]            hwlp_dec_cnt_id_o;
   logic [N_REGS-1:0]            hwlp_active_o;

   modport master (
      output hwlp_start_data_i, hwlp_end_data_i, hwlp_cnt_data_i,
             hwlp_we_i, hwlp_regid_i, valid_i, flush_i, hwlp_dec_cnt_i,
      input  hwlp_start_addr_o, hwlp_end_addr_o, hwlp_counter_o,
             hwlp_dec_cnt_id_o, hwlp_active_o
   );

   modport slave (
      input  hwlp_start_data_i, hwlp_end_data_i, hwlp_cnt_data_i,
             hwlp_we_i, hwlp_regid_i, valid_i, flush_i, hwlp_dec_cnt_i,
      output hwlp_start_addr_o, hwlp_end_addr_o, hwlp_counter_o,
             hwlp_dec_cnt_id_o, hwlp_active_o
   );
endinterface

// File: rtl/riscv_hwloop_regs.sv
// Hardware-loop register sets (start, end, counter per set).
// Ports:
//   clk  : single clock, all state updates on rising edge
//   rst  : asynchronous active-high reset, clears all state
//   bus  : riscv_hwloop_regs_if slave modport (writes, decrements, read-back)
// Counters decrement (saturating at 0) on a qualified request; a same-cycle
// count write to the same set takes priority. hwlp_dec_cnt_id_o flags a
// decrement issued last cycle whose instruction was not flushed.
module riscv_hwloop_regs #(
   parameter int unsigned N_REGS     = 2,
   parameter int unsigned N_REG_BITS = $clog2(N_REGS)
) (
   input  logic                 clk,
   input  logic                 rst,
   riscv_hwloop_regs_if.slave   bus
);

   logic [N_REGS-1:0][31:0] start_q;
   logic [N_REGS-1:0][31:0] end_q;
   logic [N_REGS-1:0][31:0] cnt_q;
   logic [N_REGS-1:0]       dec_id_q;
   logic [N_REGS-1:0]       sel;
   logic [N_REGS-1:0]       active;

   // One-hot set select; an out-of-range index selects nothing.
   always_comb begin
      sel = '0;
      for (int unsigned i = 0; i < N_REGS; i++) begin
         sel[i] = (32'(bus.hwlp_regid_i) == i);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_q  <= '0;
         end_q    <= '0;
         cnt_q    <= '0;
         dec_id_q <= '0;
      end else begin
         for (int unsigned i = 0; i < N_REGS; i++) begin
            if (bus.hwlp_we_i[0] && sel[i]) start_q[i] <= bus.hwlp_start_data_i;
            if (bus.hwlp_we_i[1] && sel[i]) end_q[i]   <= bus.hwlp_end_data_i;
            // Count write wins over a decrement of the same set.
            if (bus.hwlp_we_i[2] && sel[i]) begin
               cnt_q[i] <= bus.hwlp_cnt_data_i;
            end else if (bus.hwlp_dec_cnt_i[i] && bus.valid_i && (cnt_q[i] != '0)) begin
               cnt_q[i] <= cnt_q[i] - 32'd1;
            end
            // Flush kills only the in-flight flag, not the decrement.
            dec_id_q[i] <= bus.hwlp_dec_cnt_i[i] & bus.valid_i & ~bus.flush_i;
         end
      end
   end

   always_comb begin
      active = '0;
      for (int unsigned i = 0; i < N_REGS; i++) begin
         active[i] = (cnt_q[i] != '0);
      end
   end

   assign bus.hwlp_start_addr_o = start_q;
   assign bus.hwlp_end_addr_o   = end_q;
   assign bus.hwlp_counter_o    = cnt_q;
   assign bus.hwlp_dec_cnt_id_o = dec_id_q;
   assign bus.hwlp_active_o     = active;

endmodule

// File: doc/riscv_hwloop_regs.md
RISCV_HWLOOP_REGS -- requirements
Module: riscv_hwloop_regs

Interface
REQ-001 SHALL have parameter N_REGS, default 2, number of hardware-loop register sets.
REQ-002 SHALL have parameter N_REG_BITS, default $clog2(N_REGS), width of the register-set index.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port hwlp_start_data_i, input, 32, start-address write data.
REQ-006 SHALL have port hwlp_end_data_i, input, 32, end-address write data.
REQ-007 SHALL have port hwlp_cnt_data_i, input, 32, loop-count write data.
REQ-008 SHALL have port hwlp_we_i, input, 3, write enables: bit0 start, bit1 end, bit2 count.
REQ-009 SHALL have port hwlp_regid_i, input, N_REG_BITS, target register-set index for writes.
REQ-010 SHALL have port valid_i, input, 1, ID stage instruction valid and not stalled; qualifies decrements.
REQ-011 SHALL have port flush_i, input, 1, pipeline flush; discards the in-flight decrement flags.
REQ-012 SHALL have port hwlp_dec_cnt_i, input, N_REGS, per-set decrement request from the loop controller.
REQ-013 SHALL have port hwlp_start_addr_o, output, N_REGS x 32, stored start addresses.
REQ-014 SHALL have port hwlp_end_addr_o, output, N_REGS x 32, stored end addresses.
REQ-015 SHALL have port hwlp_counter_o, output, N_REGS x 32, stored loop counters.
REQ-016 SHALL have port hwlp_dec_cnt_id_o, output, N_REGS, per-set flag: decrement issued last cycle, instruction still in flight.
REQ-017 SHALL have port hwlp_active_o, output, N_REGS, per-set flag: counter non-zero.

Function
REQ-018 Start/end/count registers SHALL each be written on the clock edge when their hwlp_we_i bit is 1 and hwlp_regid_i selects the set; other sets are unchanged.
REQ-019 Simultaneous writes to start, end and count of one set in one cycle SHALL all take effect.
REQ-020 A decrement of set i SHALL occur when hwlp_dec_cnt_i[i]=1 and valid_i=1; the counter then becomes counter-1 at the next edge.
REQ-021 A decrement with valid_i=0 SHALL be ignored, with no state change.
REQ-022 The decrement SHALL saturate: a counter of 0 stays 0, with no wrap to 0xFFFFFFFF.
REQ-023 When a count write and a decrement target the same set in the same cycle, the write SHALL win and the decrement SHALL be dropped.
REQ-024 A count write to set j and a decrement of set i (i != j) in the same cycle SHALL both take effect.
REQ-025 More than one hwlp_dec_cnt_i bit asserted SHALL decrement every flagged set independently.
REQ-026 hwlp_dec_cnt_id_o[i] SHALL be a register set to (hwlp_dec_cnt_i[i] AND valid_i), updated every cycle, for a 1-cycle pulse.
REQ-027 When flush_i=1, hwlp_dec_cnt_id_o SHALL clear to 0 at the next edge regardless of decrement requests; the counter decrement itself SHALL still occur.
REQ-028 hwlp_active_o[i] SHALL be combinational (hwlp_counter_o[i] != 0).
REQ-029 All register outputs SHALL be driven directly from flops with no combinational bypass of write data, giving 1-cycle write-to-read latency.
REQ-030 hwlp_regid_i >= N_REGS with a write enable set SHALL cause no register change.

Reset
REQ-031 On rst=1, all start, end and counter registers SHALL clear to 32'h0 asynchronously.
REQ-032 On rst=1, hwlp_dec_cnt_id_o SHALL clear to 0, and hwlp_active_o SHALL therefore read 0.
REQ-033 Reset asserted mid-loop SHALL dominate pending writes and decrements; no update SHALL occur in the cycle rst deasserts before the first rising edge.

Verification
REQ-034 Write start=0x100, end=0x120, count=3 to set 0 in one cycle -> next cycle outputs read 0x100/0x120/3 and hwlp_active_o[0]=1.
REQ-035 Count=2 in set 1, assert dec_cnt[1] with valid_i=1 for 3 cycles -> counter 1, 0, 0; hwlp_dec_cnt_id_o[1] high in each following cycle.
REQ-036 Count=5 in set 0, dec_cnt[0]=1 with valid_i=0 -> counter stays 5 and hwlp_dec_cnt_id_o[0]=0.
REQ-037 Count=4 in set 0, same-cycle count write 9 to set 0 with dec_cnt[0]=1 -> counter=9.
REQ-038 dec_cnt[0]=1, valid_i=1, flush_i=1 with counter 7 -> counter=6 and hwlp_dec_cnt_id_o[0]=0.
REQ-039 Mid-loop (counter 10) assert rst asynchronously between edges -> all outputs 0 immediately, before the next clk edge.
